// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake, registered result and flags,
// saturating shifts and a shift-and-add multiplier that iterates WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             ovfl,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_LIM = WIDTH'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t               state, state_nx;
  logic                 accept, is_mul_op;
  logic [WIDTH:0]       sum, diff;
  logic [WIDTH-1:0]     res;
  logic                 res_c, res_v;
  logic [2*WIDTH-1:0]   mcand, acc, acc_nx;
  logic [WIDTH-1:0]     mplier, mul_res;
  logic                 mul_hi, mul_ov;
  logic [CNT_W-1:0]     cnt;
  logic                 last_iter;

  // Shift amounts of WIDTH or more saturate instead of wrapping on b[SH_W-1:0].
  function automatic logic [WIDTH-1:0] shift_sat(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] amt,
                                                 input logic [1:0]       kind);
    logic signed [WIDTH-1:0] xs;
    logic [SH_W-1:0]         sh;
    logic                    big;
    xs  = x;
    sh  = amt[SH_W-1:0];
    big = (amt >= WIDTH_LIM);
    case (kind)
      2'd0:    shift_sat = big ? '0 : (x << sh);
      2'd1:    shift_sat = big ? '0 : (x >> sh);
      default: shift_sat = big ? {WIDTH{x[WIDTH-1]}} : $unsigned(xs >>> sh);
    endcase
  endfunction

  assign is_mul_op = (op == 4'b1000) || (op == 4'b1001);
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign busy      = (state == BUSY);
  assign last_iter = (state == BUSY) && (cnt == CNT_W'(1));

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    res   = a;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      4'b0000: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: res = a | b;
      4'b0011: res = a & b;
      4'b0100: res = shift_sat(a, b, 2'd0);
      4'b0101: res = shift_sat(a, b, 2'd1);
      4'b0110: res = shift_sat(a, b, 2'd2);
      default: res = a;
    endcase
  end

  always_comb begin
    acc_nx  = acc + (mplier[0] ? mcand : '0);
    mul_res = mul_hi ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
    mul_ov  = !mul_hi && (|acc_nx[2*WIDTH-1:WIDTH]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = is_mul_op ? BUSY : HOLD;
      BUSY: if (cnt == CNT_W'(1)) state_nx = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (in_valid) state_nx = is_mul_op ? BUSY : HOLD;
          else          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Result/flag register: loaded on a single-cycle accept or the last multiply step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r     <= '0;
      zero  <= 1'b1;
      carry <= 1'b0;
      ovfl  <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      if (is_mul_op) begin
        cnt <= CNT_W'(WIDTH);
      end else begin
        r     <= res;
        zero  <= (res == '0);
        carry <= res_c;
        ovfl  <= res_v;
      end
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
      if (last_iter) begin
        r     <= mul_res;
        zero  <= (mul_res == '0);
        carry <= 1'b0;
        ovfl  <= mul_ov;
      end
    end
  end

  // Multiplier datapath: operands are captured at accept, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept && is_mul_op) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      mul_hi <= op[0];
    end else if (state == BUSY) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed corner cases, randomized ops
// against an arithmetic reference model, multiplier timing, backpressure and reset abort.
module tb_alu_seq;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    op = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  r;
  logic          zero, carry, ovfl, busy;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .zero(zero), .carry(carry), .ovfl(ovfl), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model from the arithmetic definitions of each opcode.
  function automatic void model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] er, output logic ec, output logic ev);
    longint ux, uy, sx, sy, t;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    er = x; ec = 1'b0; ev = 1'b0;
    case (o)
      4'd0: begin
        t = ux + uy; er = 16'(t); ec = (t >= 65536);
        t = sx + sy; ev = (t > 32767) || (t < -32768);
      end
      4'd1: begin
        er = 16'(ux - uy); ec = (ux < uy);
        t = sx - sy; ev = (t > 32767) || (t < -32768);
      end
      4'd2: er = x | y;
      4'd3: er = x & y;
      4'd4: er = (uy >= 16) ? 16'h0000 : 16'(ux << uy);
      4'd5: er = (uy >= 16) ? 16'h0000 : 16'(ux >> uy);
      4'd6: er = (uy >= 16) ? ((sx < 0) ? 16'hFFFF : 16'h0000) : 16'(sx >>> uy);
      4'd8: begin t = ux * uy; er = 16'(t); ev = ((t / 65536) != 0); end
      4'd9: begin t = ux * uy; er = 16'(t / 65536); end
      default: er = x;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE with out_ready low; lat = edges after the accept edge
  // until out_valid is seen. Operands are scrambled while waiting.
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       output int lat, output int busy_cycles);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    lat = 0;
    busy_cycles = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cycles++;
      a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({r, zero, carry, ovfl, out_valid, busy, in_ready} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got r=%h z=%b c=%b v=%b ov=%b busy=%b rdy=%b want r=0000 z=1 c=0 v=0 ov=0 busy=0 rdy=1",
               r, zero, carry, ovfl, out_valid, busy, in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [15:0] x, y, er;
    logic        ez, ec, ev;
  } vec_t;

  task automatic test_directed();
    vec_t v [12];
    int lat, bc;
    v[0]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
    v[1]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
    v[2]  = '{4'h1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    v[3]  = '{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    v[4]  = '{4'h6, 16'h8004, 16'd2,    16'hE001, 1'b0, 1'b0, 1'b0};
    v[5]  = '{4'h6, 16'h8004, 16'd20,   16'hFFFF, 1'b0, 1'b0, 1'b0};
    v[6]  = '{4'h5, 16'h8004, 16'd16,   16'h0000, 1'b1, 1'b0, 1'b0};
    v[7]  = '{4'h4, 16'h0001, 16'd15,   16'h8000, 1'b0, 1'b0, 1'b0};
    v[8]  = '{4'h2, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    v[9]  = '{4'h3, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0};
    v[10] = '{4'h7, 16'h1234, 16'h5678, 16'h1234, 1'b0, 1'b0, 1'b0};
    v[11] = '{4'hF, 16'hABCD, 16'h0001, 16'hABCD, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      issue(v[i].o, v[i].x, v[i].y, lat, bc);
      checks++;
      if (lat !== 0) begin
        failures++;
        $display("FAIL directed_latency[%0d] got %0d want 0", i, lat);
      end
      checks++;
      if ({r, zero, carry, ovfl} !== {v[i].er, v[i].ez, v[i].ec, v[i].ev}) begin
        failures++;
        $display("FAIL directed[%0d] op=%h got r=%h z=%b c=%b v=%b want r=%h z=%b c=%b v=%b",
                 i, v[i].o, r, zero, carry, ovfl, v[i].er, v[i].ez, v[i].ec, v[i].ev);
      end
      drain();
    end
  endtask

  task automatic test_mul();
    int lat, bc;
    issue(4'h8, 16'h0100, 16'h0100, lat, bc);
    checks++;
    if (lat !== 16 || bc !== 16) begin
      failures++;
      $display("FAIL mul_timing got lat=%0d busy_cycles=%0d want 16/16", lat, bc);
    end
    checks++;
    if ({r, zero, carry, ovfl, busy} !== {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mul_result got r=%h z=%b c=%b v=%b busy=%b want r=0000 z=1 c=0 v=1 busy=0",
               r, zero, carry, ovfl, busy);
    end
    drain();
    issue(4'h9, 16'h0100, 16'h0100, lat, bc);
    checks++;
    if (lat !== 16 || r !== 16'h0001 || zero !== 1'b0) begin
      failures++;
      $display("FAIL mulh_result got r=%h z=%b lat=%0d want r=0001 z=0 lat=16", r, zero, lat);
    end
    drain();
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [15:0] x, y, er;
    logic        ec, ev;
    int          lat, bc, want_lat;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      x = 16'($urandom);
      y = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      model(o, x, y, er, ec, ev);
      want_lat = (o == 4'h8 || o == 4'h9) ? 16 : 0;
      issue(o, x, y, lat, bc);
      checks++;
      if (lat !== want_lat || {r, zero, carry, ovfl} !== {er, (er == 16'h0000), ec, ev}) begin
        failures++;
        $display("FAIL random[%0d] op=%h a=%h b=%h got r=%h z=%b c=%b v=%b lat=%0d want r=%h z=%b c=%b v=%b lat=%0d",
                 i, o, x, y, r, zero, carry, ovfl, lat, er, (er == 16'h0000), ec, ev, want_lat);
      end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs [4], ys [4], ex [4];
    logic        ec [4], ev [4];
    int          lat, bc;
    issue(4'h0, 16'h1234, 16'h1111, lat, bc);
    for (int k = 0; k < 5; k++) begin
      op = 4'h0; a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1; out_ready = 1'b0;
      tick();
      checks++;
      if ({out_valid, in_ready, r, zero, carry, ovfl} !== {1'b1, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold_stable[%0d] got ov=%b rdy=%b r=%h z=%b c=%b v=%b want ov=1 rdy=0 r=2345 z=0 c=0 v=0",
                 k, out_valid, in_ready, r, zero, carry, ovfl);
      end
    end
    for (int k = 0; k < 4; k++) begin
      xs[k] = 16'($urandom); ys[k] = 16'($urandom);
      model(4'h0, xs[k], ys[k], ex[k], ec[k], ev[k]);
    end
    for (int k = 0; k < 4; k++) begin
      op = 4'h0; a = xs[k]; b = ys[k]; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready[%0d] got %b want 1", k, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, r, carry, ovfl} !== {1'b1, ex[k], ec[k], ev[k]}) begin
        failures++;
        $display("FAIL stream_result[%0d] got ov=%b r=%h c=%b v=%b want ov=1 r=%h c=%b v=%b",
                 k, out_valid, r, carry, ovfl, ex[k], ec[k], ev[k]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stream_idle got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    bit stale;
    issue(4'h0, 16'h0001, 16'h0001, lat, bc);
    drain();
    op = 4'h8; a = 16'h1234; b = 16'h0055; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, busy, in_ready, r, zero, carry, ovfl} !== {1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mul_abort got ov=%b busy=%b rdy=%b r=%h z=%b c=%b v=%b want ov=0 busy=0 rdy=1 r=0000 z=1 c=0 v=0",
               out_valid, busy, in_ready, r, zero, carry, ovfl);
    end
    rst = 1'b0;
    stale = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL mul_abort_stale got a late result/busy want none");
    end
    issue(4'h0, 16'h0003, 16'h0004, lat, bc);
    op = 4'h0; a = 16'h0100; b = 16'h0200; in_valid = 1'b1; out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, busy, r, zero} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL reset_priority got ov=%b busy=%b r=%h z=%b want ov=0 busy=0 r=0000 z=1",
               out_valid, busy, r, zero);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority_late got ov=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
